// File: rtl/tlb_walker.sv
// Two-level page-table walker with direct-mapped directory and entry caches.
// Supports per-address invalidate, store-permission faults and an MMU-off identity bypass.
module tlb_walker #(
    parameter int DIR_IDX = 6,
    parameter int ENT_IDX = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmu_base_i,
    input  logic        mmu_we,
    output logic [31:0] mmu_base_o,
    input  logic        mmu_en_i,
    input  logic [31:0] inv_addr_i,
    input  logic        inv_we,
    input  logic [31:0] v_addr_i,
    input  logic        v_lookup,
    input  logic        v_write,
    output logic [31:0] v_ent_o,
    output logic [31:0] v_pa_o,
    output logic        v_ack_o,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic        rd_o,
    input  logic        ack_i,
    output logic        page_fault,
    output logic [31:0] page_fault_addr,
    output logic [1:0]  fault_cause
);

    localparam int DIR_DEPTH = 1 << DIR_IDX;
    localparam int DIR_TW    = 10 - DIR_IDX;
    localparam int ENT_DEPTH = 1 << ENT_IDX;
    localparam int ENT_TW    = 20 - ENT_IDX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUERY,
        S_LOAD_DIR,
        S_LOAD_ENT,
        S_END
    } state_t;

    state_t state, state_nx;

    logic [DIR_DEPTH-1:0] dir_valid;
    logic [DIR_TW-1:0]    dir_tag  [DIR_DEPTH];
    logic [20:0]          dir_data [DIR_DEPTH];
    logic [ENT_DEPTH-1:0] ent_valid;
    logic [ENT_TW-1:0]    ent_tag  [ENT_DEPTH];
    logic [31:0]          ent_data [ENT_DEPTH];

    logic [31:0] va;
    logic        write_q;
    logic        stale;
    logic [31:0] base;

    logic [DIR_IDX-1:0] dir_idx, inv_dir_idx;
    logic [DIR_TW-1:0]  dir_tag_va, inv_dir_tag;
    logic [ENT_IDX-1:0] ent_idx, inv_ent_idx;
    logic [ENT_TW-1:0]  ent_tag_va, inv_ent_tag;
    logic               dir_hit, ent_hit, inv_dir_hit, inv_ent_hit;
    logic [20:0]        dir_entry;
    logic [31:0]        ent_entry;

    logic [31:0] addr_nx, ent_nx;
    logic [1:0]  cause_nx;
    logic        finish, ent_upd, dir_fill, ent_fill;
    logic        dir_fill_we, ent_fill_we;
    logic        unused_inv_low;

    assign mmu_base_o     = base;
    assign v_ack_o        = (state == S_END);
    assign rd_o           = (state == S_LOAD_DIR) || (state == S_LOAD_ENT);
    assign unused_inv_low = ^inv_addr_i[11:0];

    assign dir_idx     = va[21+DIR_IDX:22];
    assign dir_tag_va  = va[31:22+DIR_IDX];
    assign ent_idx     = va[11+ENT_IDX:12];
    assign ent_tag_va  = va[31:12+ENT_IDX];
    assign inv_dir_idx = inv_addr_i[21+DIR_IDX:22];
    assign inv_dir_tag = inv_addr_i[31:22+DIR_IDX];
    assign inv_ent_idx = inv_addr_i[11+ENT_IDX:12];
    assign inv_ent_tag = inv_addr_i[31:12+ENT_IDX];

    assign dir_entry   = dir_data[dir_idx];
    assign ent_entry   = ent_data[ent_idx];
    assign dir_hit     = dir_valid[dir_idx] && (dir_tag[dir_idx] == dir_tag_va);
    assign ent_hit     = ent_valid[ent_idx] && (ent_tag[ent_idx] == ent_tag_va);
    assign inv_dir_hit = dir_valid[inv_dir_idx] && (dir_tag[inv_dir_idx] == inv_dir_tag);
    assign inv_ent_hit = ent_valid[inv_ent_idx] && (ent_tag[inv_ent_idx] == inv_ent_tag);

    // An invalidate aimed at the index being filled this cycle wins over the fill.
    assign dir_fill_we = dir_fill && !(inv_we && (inv_dir_idx == dir_idx));
    assign ent_fill_we = ent_fill && !(inv_we && (inv_ent_idx == ent_idx));

    function automatic logic [1:0] eval_entry(input logic [31:0] e, input logic wr);
        if (!e[0])
            return 2'b10;
        else if (wr && !e[1])
            return 2'b11;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_o;
        ent_nx   = v_ent_o;
        cause_nx = 2'b00;
        finish   = 1'b0;
        ent_upd  = 1'b0;
        dir_fill = 1'b0;
        ent_fill = 1'b0;
        case (state)
            S_IDLE: begin
                if (v_lookup)
                    state_nx = S_QUERY;
            end
            S_QUERY: begin
                if (!mmu_en_i) begin
                    ent_upd  = 1'b1;
                    ent_nx   = {va[31:12], 12'h003};
                    finish   = 1'b1;
                    state_nx = S_END;
                end else if (ent_hit) begin
                    ent_upd  = 1'b1;
                    ent_nx   = ent_entry;
                    cause_nx = eval_entry(ent_entry, write_q);
                    finish   = 1'b1;
                    state_nx = S_END;
                end else if (dir_hit) begin
                    if (dir_entry[0]) begin
                        addr_nx  = {dir_entry[20:1], va[21:12], 2'b00};
                        state_nx = S_LOAD_ENT;
                    end else begin
                        cause_nx = 2'b01;
                        finish   = 1'b1;
                        state_nx = S_END;
                    end
                end else begin
                    addr_nx  = {base[31:12], va[31:22], 2'b00};
                    state_nx = S_LOAD_DIR;
                end
            end
            S_LOAD_DIR: begin
                if (ack_i) begin
                    dir_fill = 1'b1;
                    if (!data_i[0]) begin
                        cause_nx = 2'b01;
                        finish   = 1'b1;
                        state_nx = S_END;
                    end else begin
                        addr_nx  = {data_i[31:12], va[21:12], 2'b00};
                        state_nx = S_LOAD_ENT;
                    end
                end
            end
            S_LOAD_ENT: begin
                if (ack_i) begin
                    ent_fill = 1'b1;
                    ent_upd  = 1'b1;
                    ent_nx   = data_i;
                    cause_nx = eval_entry(data_i, write_q);
                    finish   = 1'b1;
                    state_nx = S_END;
                end
            end
            S_END: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // A walk that straddles an mmu_we still returns its result but must not leave
    // entries from the old table behind, so its fills land invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            va              <= '0;
            write_q         <= 1'b0;
            stale           <= 1'b0;
            base            <= '0;
            addr_o          <= '0;
            v_ent_o         <= '0;
            v_pa_o          <= '0;
            page_fault      <= 1'b0;
            fault_cause     <= 2'b00;
            page_fault_addr <= '0;
        end else begin
            if (state == S_IDLE && v_lookup) begin
                va      <= v_addr_i;
                write_q <= v_write;
            end
            addr_o <= addr_nx;
            if (ent_upd) begin
                v_ent_o <= ent_nx;
                v_pa_o  <= {ent_nx[31:12], va[11:0]};
            end
            if (finish) begin
                page_fault      <= (cause_nx != 2'b00);
                fault_cause     <= cause_nx;
                page_fault_addr <= va;
            end else if (mmu_we) begin
                page_fault  <= 1'b0;
                fault_cause <= 2'b00;
            end
            if (mmu_we)
                base <= mmu_base_i;
            if (mmu_we && state != S_IDLE)
                stale <= 1'b1;
            else if (state == S_IDLE)
                stale <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_valid <= '0;
            ent_valid <= '0;
        end else if (mmu_we) begin
            dir_valid <= '0;
            ent_valid <= '0;
        end else begin
            if (dir_fill_we)
                dir_valid[dir_idx] <= !stale;
            if (inv_we && inv_dir_hit)
                dir_valid[inv_dir_idx] <= 1'b0;
            if (ent_fill_we)
                ent_valid[ent_idx] <= !stale;
            if (inv_we && inv_ent_hit)
                ent_valid[inv_ent_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (dir_fill_we) begin
            dir_tag[dir_idx]  <= dir_tag_va;
            dir_data[dir_idx] <= {data_i[31:12], data_i[0]};
        end
        if (ent_fill_we) begin
            ent_tag[ent_idx]  <= ent_tag_va;
            ent_data[ent_idx] <= data_i;
        end
    end

endmodule

// File: tb/tb_tlb_walker.sv
// Directed self-checking bench for tlb_walker; a small table-driven memory answers
// walk reads with a chosen latency.
module tb_tlb_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mmu_base_i;
    logic        mmu_we;
    logic [31:0] mmu_base_o;
    logic        mmu_en_i;
    logic [31:0] inv_addr_i;
    logic        inv_we;
    logic [31:0] v_addr_i;
    logic        v_lookup;
    logic        v_write;
    logic [31:0] v_ent_o;
    logic [31:0] v_pa_o;
    logic        v_ack_o;
    logic [31:0] addr_o;
    logic [31:0] data_i;
    logic        rd_o;
    logic        ack_i;
    logic        page_fault;
    logic [31:0] page_fault_addr;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [31:0]];

    int          lat, nrd;
    logic [31:0] ra0, ra1;
    logic        unstable;

    always #5 clk = ~clk;

    tlb_walker #(.DIR_IDX(6), .ENT_IDX(6)) dut (
        .clk(clk), .rst(rst),
        .mmu_base_i(mmu_base_i), .mmu_we(mmu_we), .mmu_base_o(mmu_base_o),
        .mmu_en_i(mmu_en_i),
        .inv_addr_i(inv_addr_i), .inv_we(inv_we),
        .v_addr_i(v_addr_i), .v_lookup(v_lookup), .v_write(v_write),
        .v_ent_o(v_ent_o), .v_pa_o(v_pa_o), .v_ack_o(v_ack_o),
        .addr_o(addr_o), .data_i(data_i), .rd_o(rd_o), .ack_i(ack_i),
        .page_fault(page_fault), .page_fault_addr(page_fault_addr),
        .fault_cause(fault_cause)
    );

    // Issues one lookup and plays memory; returns at the negedge where v_ack_o is seen.
    // Latency counts cycles after the one in which v_lookup was high.
    task automatic run_lookup(input logic [31:0] va, input logic wr, input int mlat,
                              input int we_cyc, output int latency, output int reads,
                              output logic [31:0] a0, output logic [31:0] a1,
                              output logic moved);
        logic        new_req;
        logic        done;
        int          waited;
        logic [31:0] cur;
        latency = -1; reads = 0; a0 = '0; a1 = '0; moved = 1'b0;
        new_req = 1'b1; done = 1'b0; waited = 0; cur = '0;
        @(negedge clk);
        v_addr_i = va; v_write = wr; v_lookup = 1'b1;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            v_lookup = 1'b0;
            mmu_we   = (cyc == we_cyc);
            if (v_ack_o) begin
                latency = cyc; done = 1'b1; ack_i = 1'b0;
            end else if (rd_o) begin
                if (new_req) begin
                    cur = addr_o; waited = 0;
                    if (reads == 0) a0 = cur; else a1 = cur;
                    reads++; new_req = 1'b0;
                end else if (addr_o !== cur) begin
                    moved = 1'b1;
                end
                if (waited >= mlat) begin
                    ack_i = 1'b1; data_i = mem.exists(cur) ? mem[cur] : 32'h0; new_req = 1'b1;
                end else begin
                    ack_i = 1'b0; waited++;
                end
            end else begin
                ack_i = 1'b0; new_req = 1'b1;
            end
        end
        mmu_we = 1'b0; ack_i = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL lookup_timeout va=%h: no v_ack_o within 60 cycles", va);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mmu_base_i = 32'h0001_0000; mmu_we = 1'b0; mmu_en_i = 1'b1;
        inv_addr_i = '0; inv_we = 1'b0; v_addr_i = '0; v_lookup = 1'b0; v_write = 1'b0;
        data_i = '0; ack_i = 1'b0;
        #12;
        checks++; if (v_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 0", v_ack_o); end
        checks++; if (rd_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd got %b want 0", rd_o); end
        checks++; if (page_fault !== 1'b0 || fault_cause !== 2'b00) begin errors++; $display("[TB] FAIL reset_fault got %b/%b want 0/00", page_fault, fault_cause); end
        checks++; if (addr_o !== 32'h0 || mmu_base_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h/%h want 0/0", addr_o, mmu_base_o); end
        checks++; if (v_ent_o !== 32'h0 || v_pa_o !== 32'h0 || page_fault_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h/%h/%h want zeros", v_ent_o, v_pa_o, page_fault_addr); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); mmu_we = 1'b1;
        @(negedge clk); mmu_we = 1'b0;
        checks++; if (mmu_base_o !== 32'h0001_0000) begin errors++; $display("[TB] FAIL base_load got %h want 00010000", mmu_base_o); end
    endtask

    task automatic test_full_walk();
        mem[32'h0001_0004] = 32'h0002_0001;
        mem[32'h0002_000C] = 32'h0055_5003;
        run_lookup(32'h0040_3123, 1'b0, 1, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL walk_latency got %0d want 6", lat); end
        checks++; if (nrd !== 2 || ra0 !== 32'h0001_0004 || ra1 !== 32'h0002_000C) begin errors++; $display("[TB] FAIL walk_reads got %0d %h %h want 2 00010004 0002000c", nrd, ra0, ra1); end
        checks++; if (unstable !== 1'b0) begin errors++; $display("[TB] FAIL walk_addr_stable got moved=%b want 0", unstable); end
        checks++; if (v_ent_o !== 32'h0055_5003 || v_pa_o !== 32'h0055_5123) begin errors++; $display("[TB] FAIL walk_result got %h/%h want 00555003/00555123", v_ent_o, v_pa_o); end
        checks++; if (page_fault !== 1'b0 || fault_cause !== 2'b00) begin errors++; $display("[TB] FAIL walk_fault got %b/%b want 0/00", page_fault, fault_cause); end
    endtask

    task automatic test_hit();
        run_lookup(32'h0040_3123, 1'b0, 1, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 2 || nrd !== 0) begin errors++; $display("[TB] FAIL hit_latency got lat=%0d reads=%0d want 2/0", lat, nrd); end
        checks++; if (v_pa_o !== 32'h0055_5123) begin errors++; $display("[TB] FAIL hit_pa got %h want 00555123", v_pa_o); end
    endtask

    task automatic test_write_fault();
        mem[32'h0002_0010] = 32'h0055_5001;
        run_lookup(32'h0040_4010, 1'b1, 1, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 4 || nrd !== 1 || ra0 !== 32'h0002_0010) begin errors++; $display("[TB] FAIL dirhit_walk got lat=%0d reads=%0d addr=%h want 4/1/00020010", lat, nrd, ra0); end
        checks++; if (page_fault !== 1'b1 || fault_cause !== 2'b11 || page_fault_addr !== 32'h0040_4010) begin errors++; $display("[TB] FAIL ro_fault got %b/%b/%h want 1/11/00404010", page_fault, fault_cause, page_fault_addr); end
        checks++; if (v_ent_o !== 32'h0055_5001) begin errors++; $display("[TB] FAIL ro_entry got %h want 00555001", v_ent_o); end
        run_lookup(32'h0040_4010, 1'b0, 1, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 2 || page_fault !== 1'b0 || fault_cause !== 2'b00) begin errors++; $display("[TB] FAIL load_after_ro got lat=%0d pf=%b cause=%b want 2/0/00", lat, page_fault, fault_cause); end
        checks++; if (v_pa_o !== 32'h0055_5010) begin errors++; $display("[TB] FAIL load_after_ro_pa got %h want 00555010", v_pa_o); end
    endtask

    task automatic test_dir_fault();
        run_lookup(32'h0080_0000, 1'b0, 1, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 4 || nrd !== 1 || ra0 !== 32'h0001_0008) begin errors++; $display("[TB] FAIL dir_np_walk got lat=%0d reads=%0d addr=%h want 4/1/00010008", lat, nrd, ra0); end
        checks++; if (page_fault !== 1'b1 || fault_cause !== 2'b01 || page_fault_addr !== 32'h0080_0000) begin errors++; $display("[TB] FAIL dir_np_fault got %b/%b/%h want 1/01/00800000", page_fault, fault_cause, page_fault_addr); end
        run_lookup(32'h0080_0000, 1'b0, 1, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 2 || nrd !== 0 || fault_cause !== 2'b01) begin errors++; $display("[TB] FAIL dir_np_cached got lat=%0d reads=%0d cause=%b want 2/0/01", lat, nrd, fault_cause); end
        @(negedge clk); inv_addr_i = 32'h0080_0000; inv_we = 1'b1;
        @(negedge clk); inv_we = 1'b0;
        run_lookup(32'h0080_0000, 1'b0, 1, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 4 || nrd !== 1 || ra0 !== 32'h0001_0008) begin errors++; $display("[TB] FAIL inv_reread got lat=%0d reads=%0d addr=%h want 4/1/00010008", lat, nrd, ra0); end
    endtask

    task automatic test_flush_clears_fault();
        @(negedge clk); mmu_we = 1'b1;
        @(negedge clk); mmu_we = 1'b0;
        checks++; if (page_fault !== 1'b0 || fault_cause !== 2'b00) begin errors++; $display("[TB] FAIL flush_fault got %b/%b want 0/00", page_fault, fault_cause); end
    endtask

    task automatic test_bypass();
        mmu_en_i = 1'b0;
        run_lookup(32'h1234_5678, 1'b1, 1, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 2 || nrd !== 0) begin errors++; $display("[TB] FAIL bypass_latency got lat=%0d reads=%0d want 2/0", lat, nrd); end
        checks++; if (v_pa_o !== 32'h1234_5678 || v_ent_o !== 32'h1234_5003 || page_fault !== 1'b0) begin errors++; $display("[TB] FAIL bypass_result got %h/%h/%b want 12345678/12345003/0", v_pa_o, v_ent_o, page_fault); end
        mmu_en_i = 1'b1;
    endtask

    task automatic test_mmu_we_mid_walk();
        mem[32'h0002_0014] = 32'h0066_6003;
        run_lookup(32'h0040_3123, 1'b0, 0, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 4 || nrd !== 2) begin errors++; $display("[TB] FAIL refill_after_flush got lat=%0d reads=%0d want 4/2", lat, nrd); end
        run_lookup(32'h0040_5000, 1'b0, 2, 2, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 5 || nrd !== 1 || ra0 !== 32'h0002_0014) begin errors++; $display("[TB] FAIL midwalk_flush got lat=%0d reads=%0d addr=%h want 5/1/00020014", lat, nrd, ra0); end
        checks++; if (v_ent_o !== 32'h0066_6003 || v_pa_o !== 32'h0066_6000) begin errors++; $display("[TB] FAIL midwalk_result got %h/%h want 00666003/00666000", v_ent_o, v_pa_o); end
        run_lookup(32'h0040_5000, 1'b0, 0, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 4 || nrd !== 2 || ra0 !== 32'h0001_0004 || ra1 !== 32'h0002_0014) begin errors++; $display("[TB] FAIL stale_fill got lat=%0d reads=%0d %h %h want 4/2 00010004 00020014", lat, nrd, ra0, ra1); end
        run_lookup(32'h0040_5000, 1'b0, 0, 0, lat, nrd, ra0, ra1, unstable);
        checks++; if (lat !== 2 || nrd !== 0) begin errors++; $display("[TB] FAIL hit_after_refill got lat=%0d reads=%0d want 2/0", lat, nrd); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); v_addr_i = 32'h00C0_0000; v_write = 1'b0; v_lookup = 1'b1;
        @(negedge clk); v_lookup = 1'b0;
        @(negedge clk);
        checks++; if (rd_o !== 1'b1 || addr_o !== 32'h0001_000C) begin errors++; $display("[TB] FAIL pre_reset_rd got %b/%h want 1/0001000c", rd_o, addr_o); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rd_o !== 1'b0 || v_ack_o !== 1'b0 || addr_o !== 32'h0 || mmu_base_o !== 32'h0) begin errors++; $display("[TB] FAIL async_reset got rd=%b ack=%b addr=%h base=%h want 0/0/0/0", rd_o, v_ack_o, addr_o, mmu_base_o); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (rd_o !== 1'b0 || v_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got rd=%b ack=%b want 0/0", rd_o, v_ack_o); end
    endtask

    initial begin
        test_reset();
        test_full_walk();
        test_hit();
        test_write_fault();
        test_dir_fault();
        test_flush_clears_fault();
        test_bypass();
        test_mmu_we_mid_walk();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
